riscv_str_seq: RTL

//  Sequencer driving riscv_str_ops over a whole in-memory string instead of one register operand.

---
 rtl/riscv_str_seq_if.sv | 46 ++++
 rtl/riscv_str_seq.sv | 136 +++++++++++++
 2 files changed

// File: rtl/riscv_str_seq_if.sv
// Purpose: handshake and bus bundle for riscv_str_seq. It groups the core start/done
// handshake, the data-port master signals and the riscv_str_ops hookup.
//   master : the sequencer side. It drives busy/done/words, data_req/we/be/addr/wdata
//            and str_en/op/operand.
//   slave  : the environment side (core, memory port and str_ops).
interface riscv_str_seq_if #(
    parameter int unsigned LEN_WIDTH    = 16,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned STR_OP_WIDTH = 2
);
    logic                    start_i;
    logic [STR_OP_WIDTH-1:0] op_i;
    logic [ADDR_WIDTH-1:0]   addr_i;
    logic [LEN_WIDTH-1:0]    len_i;
    logic                    busy_o;
    logic                    done_o;
    logic [LEN_WIDTH-1:0]    words_o;
    logic                    data_req_o;
    logic                    data_gnt_i;
    logic                    data_rvalid_i;
    logic                    data_we_o;
    logic [3:0]              data_be_o;
    logic [ADDR_WIDTH-1:0]   data_addr_o;
    logic [31:0]             data_wdata_o;
    logic [31:0]             data_rdata_i;
    logic                    str_en_o;
    logic [STR_OP_WIDTH-1:0] str_op_o;
    logic [31:0]             str_operand_o;
    logic [31:0]             str_result_i;

    modport master (
        input  start_i, op_i, addr_i, len_i,
        input  data_gnt_i, data_rvalid_i, data_rdata_i, str_result_i,
        output busy_o, done_o, words_o,
        output data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
        output str_en_o, str_op_o, str_operand_o
    );

    modport slave (
        output start_i, op_i, addr_i, len_i,
        output data_gnt_i, data_rvalid_i, data_rdata_i, str_result_i,
        input  busy_o, done_o, words_o,
        input  data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
        input  str_en_o, str_op_o, str_operand_o
    );
endinterface

// File: rtl/riscv_str_seq.sv
// Purpose: walks an in-memory string one word at a time. For each word it reads the
// word, passes it through riscv_str_ops and writes the result back. It is a second
// data-port master beside the LSU, and only one bus transaction is ever outstanding.
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   bus      : riscv_str_seq_if.master, which carries
//              - the start/op/addr/len/busy/done/words handshake with the core,
//              - the data port (req/gnt/rvalid/we/be/addr/wdata/rdata),
//              - the str_ops hookup (en/op/operand out, result in).
module riscv_str_seq #(
    parameter int unsigned LEN_WIDTH    = 16,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned STR_OP_WIDTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    riscv_str_seq_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_WR_REQ,
        S_WR_WAIT,
        S_DONE
    } state_t;

    state_t               state;
    logic [LEN_WIDTH-1:0] len_q;

    logic [LEN_WIDTH:0]   len_ext_c;
    logic [LEN_WIDTH-1:0] nwords_c;
    logic [LEN_WIDTH-1:0] words_inc_c;
    logic [3:0]           last_be_c;
    logic                 is_last_c;

    // Word count and tail byte enables derived from the latched length.
    always_comb begin
        len_ext_c   = (LEN_WIDTH + 1)'(len_q) + (LEN_WIDTH + 1)'(3);
        nwords_c    = LEN_WIDTH'(len_ext_c >> 2);
        words_inc_c = bus.words_o + LEN_WIDTH'(1);
        is_last_c   = (words_inc_c == nwords_c);
        last_be_c   = (len_q[1:0] == 2'd0) ? 4'hF : 4'((4'h1 << len_q[1:0]) - 4'h1);
    end

    // The write data is the live str_ops result for the operand held during WR_REQ.
    assign bus.data_wdata_o = (state == S_WR_REQ) ? bus.str_result_i : 32'h0;

    // Sequencer FSM. Each branch loads the outputs for the state it enters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= S_IDLE;
            len_q             <= '0;
            bus.busy_o        <= 1'b0;
            bus.done_o        <= 1'b0;
            bus.words_o       <= '0;
            bus.data_req_o    <= 1'b0;
            bus.data_we_o     <= 1'b0;
            bus.data_be_o     <= 4'h0;
            bus.data_addr_o   <= '0;
            bus.str_en_o      <= 1'b0;
            bus.str_op_o      <= STR_OP_WIDTH'(0);
            bus.str_operand_o <= 32'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    bus.done_o <= 1'b0;
                    if (bus.start_i) begin
                        len_q           <= bus.len_i;
                        bus.str_op_o    <= bus.op_i;
                        bus.data_addr_o <= {bus.addr_i[ADDR_WIDTH-1:2], 2'b00};
                        bus.words_o     <= '0;
                        bus.busy_o      <= 1'b1;
                        if (bus.len_i == '0) begin
                            bus.done_o <= 1'b1;
                            state      <= S_DONE;
                        end else begin
                            bus.data_req_o <= 1'b1;
                            bus.data_we_o  <= 1'b0;
                            bus.data_be_o  <= 4'hF;
                            state          <= S_RD_REQ;
                        end
                    end
                end
                S_RD_REQ: begin
                    if (bus.data_gnt_i) begin
                        bus.data_req_o <= 1'b0;
                        state          <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    if (bus.data_rvalid_i) begin
                        bus.str_operand_o <= bus.data_rdata_i;
                        bus.str_en_o      <= 1'b1;
                        bus.data_req_o    <= 1'b1;
                        bus.data_we_o     <= 1'b1;
                        bus.data_be_o     <= is_last_c ? last_be_c : 4'hF;
                        state             <= S_WR_REQ;
                    end
                end
                S_WR_REQ: begin
                    if (bus.data_gnt_i) begin
                        bus.data_req_o <= 1'b0;
                        bus.data_we_o  <= 1'b0;
                        bus.str_en_o   <= 1'b0;
                        state          <= S_WR_WAIT;
                    end
                end
                S_WR_WAIT: begin
                    if (bus.data_rvalid_i) begin
                        bus.words_o     <= words_inc_c;
                        bus.data_addr_o <= bus.data_addr_o + ADDR_WIDTH'(4);
                        if (is_last_c) begin
                            bus.done_o <= 1'b1;
                            state      <= S_DONE;
                        end else begin
                            bus.data_req_o <= 1'b1;
                            bus.data_be_o  <= 4'hF;
                            state          <= S_RD_REQ;
                        end
                    end
                end
                S_DONE: begin
                    bus.done_o <= 1'b0;
                    bus.busy_o <= 1'b0;
                    state      <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
